// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and an
// optional two-entry skid buffer that registers the upstream ready path.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH      = 96,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    parameter bit               SKID       = 1'b1,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] w_main_data_d;
    logic [WIDTH-1:0] r_skid_data;
    logic [WIDTH-1:0] w_skid_data_d;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_accept;
    logic             w_deliver;

    assign w_accept  = in_valid && in_ready;
    assign w_deliver = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StEmpty;
            r_main_data <= BUBBLE_VAL;
            r_skid_data <= BUBBLE_VAL;
        end else begin
            r_state     <= w_state_d;
            r_main_data <= w_main_data_d;
            r_skid_data <= w_skid_data_d;
        end
    end

    // Flush wins over any same-cycle accept or deliver.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StEmpty: if (w_accept) w_state_d = StFull;
            StFull: begin
                if (w_accept && !w_deliver) w_state_d = StSkid;
                else if (!w_accept && w_deliver) w_state_d = StEmpty;
            end
            StSkid:  if (w_deliver) w_state_d = StFull;
            default: w_state_d = StEmpty;
        endcase
        if (flush) w_state_d = StEmpty;
    end

    always_comb begin
        w_main_data_d = r_main_data;
        w_skid_data_d = r_skid_data;
        if (flush) begin
            w_main_data_d = BUBBLE_VAL;
        end else begin
            case (r_state)
                StEmpty: if (w_accept) w_main_data_d = in_data;
                StFull: begin
                    if (w_accept && w_deliver) w_main_data_d = in_data;
                    else if (w_accept) w_skid_data_d = in_data;
                    else if (w_deliver) w_main_data_d = BUBBLE_VAL;
                end
                StSkid:  if (w_deliver) w_main_data_d = r_skid_data;
                default: w_main_data_d = BUBBLE_VAL;
            endcase
        end
    end

    always_comb begin
        out_valid = (r_state != StEmpty);
        out_data  = out_valid ? r_main_data : BUBBLE_VAL;
        stall_cnt = r_stall_cnt;
    end

    generate
        if (SKID) begin : g_skid
            logic r_in_ready;
            // Registered ready: depends only on next state, never on out_ready directly.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_in_ready <= 1'b1;
                else     r_in_ready <= (w_state_d != StSkid);
            end
            assign in_ready = r_in_ready;
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid, non-skid and narrow-counter instances of pipe_stage_reg.
module tb_pipe_stage_reg;

    localparam logic [31:0] BUB = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
    logic [31:0] s_in_data, s_out_data;
    logic [15:0] s_stall;
    logic        n_in_valid, n_in_ready, n_flush, n_out_valid, n_out_ready;
    logic [31:0] n_in_data, n_out_data;
    logic [15:0] n_stall;
    logic        c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
    logic [31:0] c_in_data, c_out_data;
    logic [3:0]  c_stall;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.WIDTH(32), .BUBBLE_VAL(BUB), .SKID(1'b1), .CNT_W(16)) u_skid (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .flush(s_flush), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .stall_cnt(s_stall)
    );

    pipe_stage_reg #(.WIDTH(32), .BUBBLE_VAL(BUB), .SKID(1'b0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_data(n_in_data), .flush(n_flush), .out_valid(n_out_valid),
        .out_ready(n_out_ready), .out_data(n_out_data), .stall_cnt(n_stall)
    );

    pipe_stage_reg #(.WIDTH(32), .BUBBLE_VAL(BUB), .SKID(1'b1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .flush(c_flush), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .stall_cnt(c_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        {s_in_valid, s_flush, s_out_ready, s_in_data} = '0;
        {n_in_valid, n_flush, n_out_ready, n_in_data} = '0;
        {c_in_valid, c_flush, c_out_ready, c_in_data} = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_s_valid", 32'(s_out_valid), 32'd0);
        chk("rst_s_data", s_out_data, BUB);
        chk("rst_s_ready", 32'(s_in_ready), 32'd1);
        chk("rst_s_stall", 32'(s_stall), 32'd0);
        chk("rst_n_valid", 32'(n_out_valid), 32'd0);
        chk("rst_n_ready", 32'(n_in_ready), 32'd1);
        chk("rst_c_stall", 32'(c_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Skid mode: stream 8 beats at full rate.
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_in_data = 32'(i);
            tick();
            chk("s_stream_valid", 32'(s_out_valid), 32'd1);
            chk("s_stream_data", s_out_data, 32'(i));
            chk("s_stream_ready", 32'(s_in_ready), 32'd1);
        end
        chk("s_stream_stall", 32'(s_stall), 32'd0);

        // Downstream stalls for 5 cycles while beat 8 is held; beat 9 lands in skid.
        s_out_ready = 1'b0;
        s_in_data   = 32'd9;
        #1 chk("s_ready_full", 32'(s_in_ready), 32'd1);
        tick();
        chk("s_ready_skid", 32'(s_in_ready), 32'd0);
        chk("s_hold_data", s_out_data, 32'd8);
        s_in_data = 32'd10;
        repeat (4) tick();
        chk("s_stall5", 32'(s_stall), 32'd5);
        chk("s_hold_data5", s_out_data, 32'd8);
        chk("s_ready_still0", 32'(s_in_ready), 32'd0);
        s_out_ready = 1'b1;
        tick();
        chk("s_rel_data9", s_out_data, 32'd9);
        chk("s_rel_ready", 32'(s_in_ready), 32'd1);
        tick();
        chk("s_rel_data10", s_out_data, 32'd10);

        // Re-enter SKID, then flush with a beat on the input.
        s_in_data   = 32'd11;
        s_out_ready = 1'b0;
        tick();
        chk("s_skid2_ready", 32'(s_in_ready), 32'd0);
        chk("s_skid2_data", s_out_data, 32'd10);
        s_flush   = 1'b1;
        s_in_data = 32'd12;
        tick();
        chk("s_flush_valid", 32'(s_out_valid), 32'd0);
        chk("s_flush_data", s_out_data, BUB);
        chk("s_flush_ready", 32'(s_in_ready), 32'd1);
        chk("s_flush_stall", 32'(s_stall), 32'd7);
        s_flush     = 1'b0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        tick();
        chk("s_drop_valid", 32'(s_out_valid), 32'd0);

        // Non-skid mode: in_ready follows out_ready combinationally.
        n_out_ready = 1'b1;
        n_in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            n_in_data = 32'(i);
            tick();
            chk("n_stream_data", n_out_data, 32'(i));
        end
        n_in_data   = 32'd4;
        n_out_ready = 1'b0;
        #1 chk("n_ready_comb0", 32'(n_in_ready), 32'd0);
        n_out_ready = 1'b1;
        #1 chk("n_ready_comb1", 32'(n_in_ready), 32'd1);
        n_out_ready = 1'b0;
        repeat (5) tick();
        chk("n_stall5", 32'(n_stall), 32'd5);
        chk("n_hold_data", n_out_data, 32'd3);
        chk("n_hold_ready", 32'(n_in_ready), 32'd0);
        n_out_ready = 1'b1;
        #1 chk("n_rel_ready", 32'(n_in_ready), 32'd1);
        tick();
        chk("n_rel_data4", n_out_data, 32'd4);
        n_in_valid = 1'b0;
        tick();
        chk("n_empty_valid", 32'(n_out_valid), 32'd0);
        chk("n_empty_data", n_out_data, BUB);
        n_in_valid = 1'b1;
        n_in_data  = 32'd5;
        tick();
        chk("n_data5", n_out_data, 32'd5);
        n_flush   = 1'b1;
        n_in_data = 32'd6;
        tick();
        chk("n_flush_valid", 32'(n_out_valid), 32'd0);
        chk("n_flush_data", n_out_data, BUB);
        chk("n_flush_ready", 32'(n_in_ready), 32'd1);
        chk("n_flush_stall", 32'(n_stall), 32'd5);
        n_flush    = 1'b0;
        n_in_valid = 1'b0;
        tick();
        chk("n_drop_valid", 32'(n_out_valid), 32'd0);

        // 4-bit counter saturates and survives flush.
        c_in_valid = 1'b1;
        c_in_data  = 32'h55;
        tick();
        chk("c_load_data", c_out_data, 32'h55);
        c_in_valid = 1'b0;
        repeat (20) tick();
        chk("c_sat", 32'(c_stall), 32'd15);
        chk("c_sat_data", c_out_data, 32'h55);
        c_flush = 1'b1;
        tick();
        c_flush = 1'b0;
        chk("c_flush_valid", 32'(c_out_valid), 32'd0);
        chk("c_sat_after_flush", 32'(c_stall), 32'd15);

        // Asynchronous reset between edges while streaming.
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        s_in_data   = 32'h21;
        tick();
        chk("s_pre_rst21", s_out_data, 32'h21);
        s_in_data = 32'h22;
        tick();
        chk("s_pre_rst22", s_out_data, 32'h22);
        #2 rst = 1'b1;
        #1;
        chk("arst_s_valid", 32'(s_out_valid), 32'd0);
        chk("arst_s_ready", 32'(s_in_ready), 32'd1);
        chk("arst_s_stall", 32'(s_stall), 32'd0);
        chk("arst_n_stall", 32'(n_stall), 32'd0);
        chk("arst_c_stall", 32'(c_stall), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        s_in_data = 32'h31;
        tick();
        chk("resume31", s_out_data, 32'h31);
        s_in_data = 32'h32;
        tick();
        chk("resume32", s_out_data, 32'h32);
        s_in_valid = 1'b0;
        tick();
        chk("resume_empty", 32'(s_out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
